// File: rtl/uart_obi_if.sv
// OBI slave-port bundle for the UART register block.
interface uart_obi_if;
    logic        req_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/uart_obi.sv
// 8N1 UART with TX FIFO, single-byte RX buffer and an OBI register interface.
module uart_obi #(
    parameter int unsigned TX_DEPTH = 4,
    parameter logic [15:0] BAUD_RST = 16'd434
) (
    input  logic      clk,
    input  logic      rst,
    uart_obi_if.slave bus,
    output logic      uart_tx_o,
    input  logic      uart_rx_i
);
    localparam int unsigned PTR_W = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_BAUD   = 3'd2;
    localparam logic [2:0] A_TXDATA = 3'd3;
    localparam logic [2:0] A_RXDATA = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

    logic        tx_en_q, rx_en_q;
    logic [15:0] baud_q, baud_eff_c;
    logic [2:0]  sel_c;
    logic        wr_c, rd_c, rd_rxdata_c;
    logic [31:0] rd_val_c;

    logic [7:0]       fifo_mem [TX_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] fifo_cnt_q;
    logic             fifo_full_c, fifo_push_c;

    uart_state_e tx_state_q, tx_state_nxt;
    logic [15:0] tx_cnt_q, tx_div_q;
    logic [2:0]  tx_idx_q;
    logic [7:0]  tx_shift_q;
    logic        tx_bit_done_c, tx_avail_c, tx_pop_c, tx_line_c, tx_idle_c;

    uart_state_e rx_state_q, rx_state_nxt;
    logic [1:0]  rx_sync_q;
    logic        rx_s, rx_prev_q, rx_go_c;
    logic [15:0] rx_cnt_q, rx_div_q, rx_half_c;
    logic [2:0]  rx_idx_q;
    logic [7:0]  rx_shift_q, rx_buf_q;
    logic        rx_bit_done_c, rx_half_hit_c;
    logic        rx_start_c, rx_sample_c, rx_done_c, rx_ferr_c;
    logic        rx_valid_q, rx_ovr_q, rx_ferr_q;

    logic unused;
    assign unused = ^{bus.addr_i[31:5], bus.addr_i[1:0], bus.be_i[3:1], bus.wdata_i[31:16]};

    // Bus decode; every request is granted immediately
    assign bus.gnt_o   = bus.req_i;
    assign sel_c       = bus.addr_i[4:2];
    assign wr_c        = bus.req_i & bus.we_i & bus.be_i[0];
    assign rd_c        = bus.req_i & ~bus.we_i;
    assign rd_rxdata_c = rd_c && (sel_c == A_RXDATA);
    assign baud_eff_c  = (baud_q == 16'd0) ? 16'd1 : baud_q;

    assign fifo_full_c = (fifo_cnt_q == CNT_W'(TX_DEPTH));
    assign fifo_push_c = wr_c && (sel_c == A_TXDATA) && (!fifo_full_c || tx_pop_c);
    assign tx_idle_c   = (fifo_cnt_q == '0) && (tx_state_q == S_IDLE);

    always_comb begin
        rd_val_c = '0;
        case (sel_c)
            A_CTRL:   rd_val_c = {30'd0, rx_en_q, tx_en_q};
            A_STATUS: rd_val_c = {27'd0, rx_ferr_q, rx_ovr_q, rx_valid_q, tx_idle_c, fifo_full_c};
            A_BAUD:   rd_val_c = {16'd0, baud_q};
            A_RXDATA: rd_val_c = rx_valid_q ? {24'd0, rx_buf_q} : '0;
            default:  rd_val_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_en_q      <= 1'b0;
            rx_en_q      <= 1'b0;
            baud_q       <= BAUD_RST;
            bus.rvalid_o <= 1'b0;
            bus.rdata_o  <= '0;
        end else begin
            bus.rvalid_o <= bus.req_i;
            bus.rdata_o  <= rd_c ? rd_val_c : '0;
            if (wr_c && sel_c == A_CTRL) begin
                tx_en_q <= bus.wdata_i[0];
                rx_en_q <= bus.wdata_i[1];
            end
            if (wr_c && sel_c == A_BAUD) baud_q <= bus.wdata_i[15:0];
        end
    end

    // TX FIFO: a push into a full FIFO is accepted only alongside a pop
    always_ff @(posedge clk) begin
        if (fifo_push_c) fifo_mem[wr_ptr_q] <= bus.wdata_i[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (tx_pop_c)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({fifo_push_c, tx_pop_c})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // TX FSM
    assign tx_bit_done_c = (tx_cnt_q == tx_div_q);
    assign tx_avail_c    = tx_en_q && (fifo_cnt_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state_q <= S_IDLE;
        else     tx_state_q <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state_q;
        case (tx_state_q)
            S_IDLE:  if (tx_avail_c) tx_state_nxt = S_START;
            S_START: if (tx_bit_done_c) tx_state_nxt = S_DATA;
            S_DATA:  if (tx_bit_done_c && tx_idx_q == 3'd7) tx_state_nxt = S_STOP;
            S_STOP:  if (tx_bit_done_c) tx_state_nxt = tx_avail_c ? S_START : S_IDLE;
            default: tx_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx_pop_c  = 1'b0;
        tx_line_c = 1'b1;
        case (tx_state_q)
            S_IDLE:  tx_pop_c  = tx_avail_c;
            S_START: tx_line_c = 1'b0;
            S_DATA:  tx_line_c = tx_shift_q[0];
            S_STOP:  tx_pop_c  = tx_bit_done_c && tx_avail_c;
            default: tx_line_c = 1'b1;
        endcase
    end

    // Divider is latched at frame start so BAUD writes never disturb a frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt_q   <= '0;
            tx_div_q   <= 16'd1;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            uart_tx_o  <= 1'b1;
        end else begin
            uart_tx_o <= tx_line_c;
            if (tx_pop_c) begin
                tx_shift_q <= fifo_mem[rd_ptr_q];
                tx_div_q   <= baud_eff_c;
                tx_cnt_q   <= '0;
                tx_idx_q   <= '0;
            end else if (tx_state_q != S_IDLE) begin
                if (tx_bit_done_c) begin
                    tx_cnt_q <= '0;
                    if (tx_state_q == S_DATA) begin
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_idx_q   <= tx_idx_q + 3'd1;
                    end
                end else begin
                    tx_cnt_q <= tx_cnt_q + 16'd1;
                end
            end
        end
    end

    // RX synchronizer and falling-edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync_q <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            rx_sync_q <= {rx_sync_q[0], uart_rx_i};
            rx_prev_q <= rx_s;
        end
    end

    assign rx_s          = rx_sync_q[1];
    assign rx_go_c       = rx_en_q & rx_prev_q & ~rx_s;
    assign rx_half_c     = {1'b0, rx_div_q[15:1]};
    assign rx_half_hit_c = (rx_cnt_q == rx_half_c);
    assign rx_bit_done_c = (rx_cnt_q == rx_div_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state_q <= S_IDLE;
        else     rx_state_q <= rx_state_nxt;
    end

    always_comb begin
        rx_state_nxt = rx_state_q;
        case (rx_state_q)
            S_IDLE:  if (rx_go_c) rx_state_nxt = S_START;
            S_START: if (rx_half_hit_c) rx_state_nxt = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (rx_bit_done_c && rx_idx_q == 3'd7) rx_state_nxt = S_STOP;
            S_STOP:  if (rx_bit_done_c) rx_state_nxt = S_IDLE;
            default: rx_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rx_start_c  = 1'b0;
        rx_sample_c = 1'b0;
        rx_done_c   = 1'b0;
        rx_ferr_c   = 1'b0;
        case (rx_state_q)
            S_IDLE: rx_start_c  = rx_go_c;
            S_DATA: rx_sample_c = rx_bit_done_c;
            S_STOP: begin
                rx_done_c = rx_bit_done_c & rx_s;
                rx_ferr_c = rx_bit_done_c & ~rx_s;
            end
            default: rx_start_c = 1'b0;
        endcase
    end

    // START waits half a bit; from then on each sample lands mid-bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt_q   <= '0;
            rx_div_q   <= 16'd1;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
        end else if (rx_start_c) begin
            rx_div_q <= baud_eff_c;
            rx_cnt_q <= '0;
            rx_idx_q <= '0;
        end else if (rx_state_q == S_START) begin
            rx_cnt_q <= rx_half_hit_c ? 16'd0 : rx_cnt_q + 16'd1;
        end else if (rx_state_q != S_IDLE) begin
            if (rx_bit_done_c) begin
                rx_cnt_q <= '0;
                if (rx_sample_c) begin
                    rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                    rx_idx_q   <= rx_idx_q + 3'd1;
                end
            end else begin
                rx_cnt_q <= rx_cnt_q + 16'd1;
            end
        end
    end

    // A read racing a completion returns the old byte and does not count as overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_buf_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            if (rx_done_c) begin
                rx_buf_q   <= rx_shift_q;
                rx_valid_q <= 1'b1;
                rx_ovr_q   <= rd_rxdata_c ? 1'b0 : (rx_ovr_q | rx_valid_q);
            end else if (rd_rxdata_c) begin
                rx_valid_q <= 1'b0;
                rx_ovr_q   <= 1'b0;
            end
            if (rx_ferr_c)        rx_ferr_q <= 1'b1;
            else if (rd_rxdata_c) rx_ferr_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_obi.sv
// Scoreboard bench for uart_obi: bus reads and TX frames are checked against queued expectations.
module tb_uart_obi;
    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_STATUS = 32'h04;
    localparam logic [31:0] A_BAUD   = 32'h08;
    localparam logic [31:0] A_TXDATA = 32'h0C;
    localparam logic [31:0] A_RXDATA = 32'h10;

    logic clk = 1'b0;
    logic rst;
    logic uart_tx;
    logic uart_rx;

    uart_obi_if bif ();

    uart_obi #(.TX_DEPTH(4), .BAUD_RST(16'd434)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bif),
        .uart_tx_o (uart_tx),
        .uart_rx_i (uart_rx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_q [$];
    string       name_q [$];
    logic [7:0]  tx_q [$];
    int          start_cyc [$];
    bit          tx_busy   = 1'b0;
    bit          tx_mon_en = 1'b1;
    int          tx_period = 4;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", nm, got, exp);
        end
    endtask

    // Bus response monitor
    logic [31:0] mon_e;
    string       mon_n;
    always @(negedge clk) begin
        if (bif.rvalid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rvalid_spurious: got=1 exp=0");
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                chk(mon_n, bif.rdata_o, mon_e);
            end
        end
    end

    // TX line monitor: every cycle of every bit must hold the expected level
    initial begin : tx_mon
        logic       prev;
        logic [9:0] frame;
        logic [9:0] got;
        logic [7:0] b;
        bit         stable;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_mon_en && prev === 1'b1 && uart_tx === 1'b0) begin
                if (tx_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected_frame: got=start exp=idle");
                    b = 8'h00;
                end else begin
                    b = tx_q.pop_front();
                end
                start_cyc.push_back(cyc);
                tx_busy = 1'b1;
                frame   = {1'b1, b, 1'b0};
                got     = '0;
                stable  = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    for (int c = 0; c < tx_period; c++) begin
                        if (k != 0 || c != 0) @(negedge clk);
                        if (uart_tx !== frame[k]) stable = 1'b0;
                        if (c == tx_period / 2) got[k] = uart_tx;
                    end
                end
                chk("tx_frame", {21'd0, stable, got}, {21'd0, 1'b1, frame});
                tx_busy = 1'b0;
            end
            prev = uart_tx;
        end
    end

    task automatic bus_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] exp, input string nm);
        @(negedge clk);
        bif.req_i   = 1'b1;
        bif.we_i    = we;
        bif.addr_i  = addr;
        bif.wdata_i = wd;
        bif.be_i    = be;
        exp_q.push_back(we ? 32'h0 : exp);
        name_q.push_back(nm);
        #1 chk({nm, "_gnt"}, {31'd0, bif.gnt_o}, 32'd1);
        @(negedge clk);
        bif.req_i = 1'b0;
        bif.we_i  = 1'b0;
        bif.be_i  = 4'h0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        bus_op(1'b1, addr, wd, 4'hF, 32'h0, "wr_rdata");
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string nm);
        bus_op(1'b0, addr, 32'h0, 4'hF, exp, nm);
    endtask

    task automatic wait_tx_done(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            if (tx_q.size() == 0 && !tx_busy) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got=pending exp=done", nm);
        end
    endtask

    // Serial frame at 8 clk per bit (BAUD=7)
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            uart_rx = f[k];
            repeat (7) @(negedge clk);
        end
        @(negedge clk);
        uart_rx = 1'b1;
    endtask

    initial begin : main
        bit found;
        rst         = 1'b1;
        uart_rx     = 1'b1;
        bif.req_i   = 1'b0;
        bif.we_i    = 1'b0;
        bif.addr_i  = '0;
        bif.wdata_i = '0;
        bif.be_i    = '0;

        // Reset behaviour
        repeat (2) @(negedge clk);
        bif.req_i = 1'b1;
        #1;
        chk("rst_gnt_hi", {31'd0, bif.gnt_o}, 32'd1);
        chk("rst_rvalid", {31'd0, bif.rvalid_o}, 32'd0);
        chk("rst_rdata", bif.rdata_o, 32'd0);
        chk("rst_tx", {31'd0, uart_tx}, 32'd1);
        bif.req_i = 1'b0;
        #1 chk("rst_gnt_lo", {31'd0, bif.gnt_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd(A_STATUS, 32'h2, "rst_status");
        rd(A_BAUD, 32'd434, "rst_baud");
        rd(A_CTRL, 32'h0, "rst_ctrl");

        // Single 0xA5 frame at 4 clk per bit
        wr(A_BAUD, 32'd3);
        wr(A_CTRL, 32'h1);
        tx_q.push_back(8'hA5);
        wr(A_TXDATA, 32'hA5);
        wait_tx_done("tx_a5");
        rd(A_STATUS, 32'h2, "a5_status");
        rd(A_TXDATA, 32'h0, "txdata_wo");
        wr(32'h18, 32'hFFFF_FFFF);
        rd(32'h1C, 32'h0, "unmapped");

        // Overfill with tx disabled, then drain back-to-back
        wr(A_CTRL, 32'h0);
        for (int i = 1; i <= 5; i++) wr(A_TXDATA, 32'(i));
        rd(A_STATUS, 32'h1, "full_status");
        start_cyc.delete();
        for (int i = 1; i <= 4; i++) tx_q.push_back(8'(i));
        wr(A_CTRL, 32'h1);
        wait_tx_done("burst");
        repeat (60) @(negedge clk);
        chk("burst_frames", 32'(start_cyc.size()), 32'd4);
        if (start_cyc.size() >= 4)
            for (int i = 1; i < 4; i++) chk("burst_gap", 32'(start_cyc[i] - start_cyc[i-1]), 32'd40);
        rd(A_STATUS, 32'h2, "burst_status");

        // be_i[0]=0 write is ignored
        bus_op(1'b1, A_CTRL, 32'h0, 4'b1110, 32'h0, "be_wr");
        rd(A_CTRL, 32'h1, "be_ignored");

        // Clearing tx_en mid-frame finishes the frame and holds the rest
        tx_q.push_back(8'h5A);
        wr(A_TXDATA, 32'h5A);
        wr(A_TXDATA, 32'h33);
        wr(A_CTRL, 32'h0);
        wait_tx_done("txen_off");
        repeat (60) @(negedge clk);
        rd(A_STATUS, 32'h0, "txen_off_status");
        tx_q.push_back(8'h33);
        wr(A_CTRL, 32'h1);
        wait_tx_done("txen_on");
        rd(A_STATUS, 32'h2, "txen_on_status");

        // Receive path
        wr(A_CTRL, 32'h2);
        wr(A_BAUD, 32'd7);
        send_rx(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        rd(A_STATUS, 32'h6, "rx_status");
        rd(A_RXDATA, 32'h3C, "rx_data");
        rd(A_STATUS, 32'h2, "rx_cleared");
        rd(A_RXDATA, 32'h0, "rx_empty");

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        rd(A_STATUS, 32'hE, "ovr_status");
        send_rx(8'h55, 1'b0);
        repeat (4) @(negedge clk);
        rd(A_STATUS, 32'h1E, "ferr_status");
        rd(A_RXDATA, 32'h22, "ovr_data");
        rd(A_STATUS, 32'h2, "flags_cleared");

        // One-cycle glitch must not start a byte
        @(negedge clk);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        rd(A_STATUS, 32'h2, "glitch_status");
        rd(A_RXDATA, 32'h0, "glitch_data");

        // Reset in the middle of data bit 3
        tx_mon_en = 1'b0;
        wr(A_BAUD, 32'd3);
        wr(A_CTRL, 32'h3);
        wr(A_TXDATA, 32'h00);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (uart_tx === 1'b0) found = 1'b1;
        end
        chk("abort_start_seen", {31'd0, found}, 32'd1);
        repeat (17) @(negedge clk);
        chk("abort_pre_tx", {31'd0, uart_tx}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("abort_tx", {31'd0, uart_tx}, 32'd1);
        chk("abort_rvalid", {31'd0, bif.rvalid_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd(A_STATUS, 32'h2, "abort_status");
        rd(A_BAUD, 32'd434, "abort_baud");
        rd(A_CTRL, 32'h0, "abort_ctrl");

        repeat (5) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("tx_q_drained", 32'(tx_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
